// File: rtl/cache_pmem_arbiter_if.sv
// cache_pmem_arbiter_if: I-cache, D-cache and physical-memory miss-path signals around the arbiter
interface cache_pmem_arbiter_if #(
    parameter int s_line = 256
);
    logic              i_pmem_read;
    logic [31:0]       i_pmem_address;
    logic              i_pmem_resp;
    logic [s_line-1:0] i_pmem_rdata;
    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [31:0]       d_pmem_address;
    logic [s_line-1:0] d_pmem_wdata;
    logic              d_pmem_resp;
    logic [s_line-1:0] d_pmem_rdata;
    logic              pmem_read;
    logic              pmem_write;
    logic [31:0]       pmem_address;
    logic [s_line-1:0] pmem_wdata;
    logic              pmem_resp;
    logic [s_line-1:0] pmem_rdata;

    modport slave (
        input  i_pmem_read, i_pmem_address,
        output i_pmem_resp, i_pmem_rdata,
        input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        output d_pmem_resp, d_pmem_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_resp, pmem_rdata
    );

    modport master (
        output i_pmem_read, i_pmem_address,
        input  i_pmem_resp, i_pmem_rdata,
        output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        input  d_pmem_resp, d_pmem_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_resp, pmem_rdata
    );
endinterface

// File: rtl/cache_pmem_arbiter.sv
// cache_pmem_arbiter: shares one line-wide pmem port between I-cache and D-cache, D-priority with a streak limit
module cache_pmem_arbiter #(
    parameter int s_line       = 256,
    parameter int max_d_streak = 4
) (
    input logic                 clk,
    input logic                 rst,
    cache_pmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} state_e;

    localparam logic [3:0] streak_max = 4'(max_d_streak);

    state_e            state_q, state_d;
    logic [3:0]        streak_q, streak_d;
    logic [31:0]       addr_q, addr_d;
    logic [s_line-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              d_req, grant_i, rd, wr, i_resp, d_resp;

    assign d_req   = bus.d_pmem_read | bus.d_pmem_write;
    assign grant_i = bus.i_pmem_read & (~d_req | (streak_q == streak_max));

    // Arbitrate in IDLE, latch the winner, and decode strobes/resps from the current state
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
        rd       = 1'b0;
        wr       = 1'b0;
        i_resp   = 1'b0;
        d_resp   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d  = I_BUSY;
                    addr_d   = bus.i_pmem_address;
                    streak_d = '0;
                end else if (d_req) begin
                    state_d  = D_BUSY;
                    addr_d   = bus.d_pmem_address;
                    wdata_d  = bus.d_pmem_wdata;
                    wr_d     = bus.d_pmem_write;
                    streak_d = !bus.i_pmem_read ? '0 :
                               (streak_q == streak_max) ? streak_q : streak_q + 4'd1;
                end
            end
            I_BUSY: begin
                rd      = 1'b1;
                i_resp  = bus.pmem_resp;
                state_d = bus.pmem_resp ? DONE : I_BUSY;
            end
            D_BUSY: begin
                wr      = wr_q;
                rd      = ~wr_q;
                d_resp  = bus.pmem_resp;
                state_d = bus.pmem_resp ? DONE : D_BUSY;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, streak and latched transaction; reset drops strobes immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            streak_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
        end
    end

    assign bus.pmem_read    = rd;
    assign bus.pmem_write   = wr;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;
    assign bus.i_pmem_resp  = i_resp;
    assign bus.d_pmem_resp  = d_resp;
    assign bus.i_pmem_rdata = bus.pmem_rdata;
    assign bus.d_pmem_rdata = bus.pmem_rdata;

    // D-cache must never raise read and write together at arbitration; write would be taken
    assert property (@(posedge clk) disable iff (rst)
        !(state_q == IDLE && bus.d_pmem_read && bus.d_pmem_write));
endmodule

// File: tb/tb_cache_pmem_arbiter.sv
// tb_cache_pmem_arbiter: directed self-checking bench for the I/D pmem arbiter
module tb_cache_pmem_arbiter;
    localparam logic [255:0] rd_a5 = {32{8'hA5}};
    localparam logic [255:0] rd_5a = {32{8'h5A}};
    localparam logic [255:0] wd_12 = {16{16'h1234}};

    logic        clk = 1'b0;
    logic        rst;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] exp_order [6] = '{32'h400, 32'h400, 32'h400, 32'h400, 32'h300, 32'h400};

    cache_pmem_arbiter_if bus ();

    cache_pmem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic serve(input int lat, input logic [255:0] rdata);
        for (int k = 1; k < lat; k++) step();
        bus.pmem_rdata = rdata;
        bus.pmem_resp  = 1'b1;
        #1;
    endtask

    task automatic close_xfer();
        step();
        bus.pmem_resp = 1'b0;
    endtask

    initial begin
        rst                = 1'b1;
        bus.i_pmem_read    = 1'b0;
        bus.i_pmem_address = '0;
        bus.d_pmem_read    = 1'b0;
        bus.d_pmem_write   = 1'b0;
        bus.d_pmem_address = '0;
        bus.d_pmem_wdata   = '0;
        bus.pmem_resp      = 1'b0;
        bus.pmem_rdata     = '0;
        step();
        step();
        check("rst_rd", bus.pmem_read, 1'b0);
        check("rst_wr", bus.pmem_write, 1'b0);
        check("rst_iresp", bus.i_pmem_resp, 1'b0);
        check("rst_dresp", bus.d_pmem_resp, 1'b0);
        check("rst_addr", bus.pmem_address, 32'h0);
        check("rst_wdata", bus.pmem_wdata, 256'h0);
        rst = 1'b0;

        bus.i_pmem_address = 32'h60;
        bus.i_pmem_read    = 1'b1;
        step();
        check("i_rd_c1", bus.pmem_read, 1'b1);
        check("i_addr", bus.pmem_address, 32'h60);
        check("i_wr", bus.pmem_write, 1'b0);
        step();
        check("i_rd_c2", bus.pmem_read, 1'b1);
        check("i_early_resp", bus.i_pmem_resp, 1'b0);
        step();
        check("i_rd_c3", bus.pmem_read, 1'b1);
        bus.pmem_rdata = rd_a5;
        bus.pmem_resp  = 1'b1;
        #1;
        check("i_resp", bus.i_pmem_resp, 1'b1);
        check("i_rdata", bus.i_pmem_rdata, rd_a5);
        check("i_dresp", bus.d_pmem_resp, 1'b0);
        check("i_d_rdata", bus.d_pmem_rdata, rd_a5);
        bus.i_pmem_read = 1'b0;
        close_xfer();
        bus.pmem_resp = 1'b1;
        #1;
        check("i_done_rd", bus.pmem_read, 1'b0);
        check("i_done_iresp", bus.i_pmem_resp, 1'b0);
        bus.pmem_resp = 1'b0;
        step();
        check("i_idle_rd", bus.pmem_read, 1'b0);

        bus.d_pmem_address = 32'h1F20;
        bus.d_pmem_wdata   = wd_12;
        bus.d_pmem_write   = 1'b1;
        step();
        check("dw_wr", bus.pmem_write, 1'b1);
        check("dw_rd", bus.pmem_read, 1'b0);
        check("dw_addr", bus.pmem_address, 32'h1F20);
        check("dw_wdata", bus.pmem_wdata, wd_12);
        serve(2, '0);
        check("dw_dresp", bus.d_pmem_resp, 1'b1);
        check("dw_iresp", bus.i_pmem_resp, 1'b0);
        bus.d_pmem_write = 1'b0;
        close_xfer();
        check("dw_done_wr", bus.pmem_write, 1'b0);
        check("dw_done_dresp", bus.d_pmem_resp, 1'b0);
        step();

        bus.i_pmem_address = 32'h200;
        bus.d_pmem_address = 32'h100;
        bus.i_pmem_read    = 1'b1;
        bus.d_pmem_read    = 1'b1;
        step();
        check("sim_d_addr", bus.pmem_address, 32'h100);
        check("sim_d_rd", bus.pmem_read, 1'b1);
        check("sim_d_wr", bus.pmem_write, 1'b0);
        serve(1, rd_5a);
        check("sim_dresp", bus.d_pmem_resp, 1'b1);
        check("sim_iresp", bus.i_pmem_resp, 1'b0);
        check("sim_drdata", bus.d_pmem_rdata, rd_5a);
        bus.d_pmem_read = 1'b0;
        close_xfer();
        check("sim_done_rd", bus.pmem_read, 1'b0);
        step();
        check("sim_idle_rd", bus.pmem_read, 1'b0);
        step();
        check("sim_i_rd", bus.pmem_read, 1'b1);
        check("sim_i_addr", bus.pmem_address, 32'h200);
        serve(1, rd_a5);
        check("sim_i_resp", bus.i_pmem_resp, 1'b1);
        bus.i_pmem_read = 1'b0;
        close_xfer();
        step();

        bus.i_pmem_address = 32'h300;
        bus.d_pmem_address = 32'h400;
        bus.i_pmem_read    = 1'b1;
        bus.d_pmem_read    = 1'b1;
        for (int t = 0; t < 6; t++) begin
            step();
            check($sformatf("starve_addr_%0d", t), bus.pmem_address, exp_order[t]);
            serve(1, '0);
            check($sformatf("starve_resp_%0d", t), {bus.i_pmem_resp, bus.d_pmem_resp},
                  (t == 4) ? 2'b10 : 2'b01);
            if (t == 4) bus.i_pmem_read = 1'b0;
            if (t == 5) bus.d_pmem_read = 1'b0;
            close_xfer();
            step();
        end

        bus.d_pmem_address = 32'h40;
        bus.d_pmem_read    = 1'b1;
        step();
        bus.d_pmem_address = 32'h80;
        bus.d_pmem_read    = 1'b0;
        step();
        check("drop_addr", bus.pmem_address, 32'h40);
        check("drop_rd", bus.pmem_read, 1'b1);
        serve(1, '0);
        check("drop_dresp", bus.d_pmem_resp, 1'b1);
        close_xfer();
        step();
        bus.pmem_resp = 1'b1;
        #1;
        check("stray_iresp", bus.i_pmem_resp, 1'b0);
        check("stray_dresp", bus.d_pmem_resp, 1'b0);
        step();
        check("stray_rd", bus.pmem_read, 1'b0);
        check("stray_dresp2", bus.d_pmem_resp, 1'b0);
        bus.pmem_resp = 1'b0;

        bus.i_pmem_address = 32'h500;
        bus.i_pmem_read    = 1'b1;
        step();
        check("pre_rst_rd", bus.pmem_read, 1'b1);
        #2;
        rst           = 1'b1;
        bus.pmem_resp = 1'b1;
        #1;
        check("mid_rst_rd", bus.pmem_read, 1'b0);
        check("mid_rst_iresp", bus.i_pmem_resp, 1'b0);
        step();
        bus.pmem_resp = 1'b0;
        check("post_rst_rd", bus.pmem_read, 1'b0);
        check("post_rst_addr", bus.pmem_address, 32'h0);
        rst = 1'b0;
        step();
        check("fresh_rd", bus.pmem_read, 1'b1);
        check("fresh_addr", bus.pmem_address, 32'h500);
        serve(1, rd_a5);
        check("fresh_iresp", bus.i_pmem_resp, 1'b1);
        bus.i_pmem_read = 1'b0;
        close_xfer();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cache_pmem_arbiter.md
Name: cache_pmem_arbiter

Overview:
- Shares the single 256-bit physical-memory port between the pipelined I-cache (read-only line fills) and the D-cache (line fills and write-backs).
- Sits between both cache miss paths and the cacheline memory model.
- Grants one requester at a time and latches its address and write data for the whole transaction.
- Routes the memory response back to the granted cache only.
- Policy is D-priority with an anti-starvation streak limit.

Parameters:
- s_line, 256, cacheline width in bits.
- max_d_streak, 4, maximum consecutive D grants while an I request is waiting (range 1-15).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- i_pmem_read  input  1  I-cache line-fill request
- i_pmem_address  input  32  I-cache line address
- i_pmem_resp  output  1  I-cache transaction done
- i_pmem_rdata  output  256  fill data to I-cache
- d_pmem_read  input  1  D-cache line-fill request
- d_pmem_write  input  1  D-cache write-back request
- d_pmem_address  input  32  D-cache line address
- d_pmem_wdata  input  256  D-cache write-back line
- d_pmem_resp  output  1  D-cache transaction done
- d_pmem_rdata  output  256  fill data to D-cache
- pmem_read  output  1  memory read strobe
- pmem_write  output  1  memory write strobe
- pmem_address  output  32  latched address of the granted request
- pmem_wdata  output  256  latched write-back line
- pmem_resp  input  1  memory done
- pmem_rdata  input  256  memory read data

Behaviour:
- Reset values: state IDLE, streak=0, latched address/wdata=0. All strobes and resps are 0; pmem_read/pmem_write drop asynchronously on rst.
- i_pmem_rdata and d_pmem_rdata always equal pmem_rdata. Only the resp bits qualify the data.
- States: IDLE, I_BUSY, D_BUSY, DONE.
- IDLE, arbitration:
  - D request = d_pmem_read|d_pmem_write.
  - If only I requests -> I_BUSY.
  - If only D requests -> D_BUSY.
  - If both request: D wins unless streak==max_d_streak, in which case I wins.
  - On the granting edge, latch the address; also latch wdata and the op (write if d_pmem_write) when D is granted.
  - No strobe is driven in IDLE.
- I_BUSY: pmem_read=1 from the latched address. On pmem_resp, i_pmem_resp=1 in the same cycle (combinational), then -> DONE.
- D_BUSY: pmem_write=1 if the latched op is write, otherwise pmem_read=1. On pmem_resp, d_pmem_resp=1 in the same cycle, then -> DONE.
- DONE: one dead cycle with no strobes. Requests are ignored so the finishing cache can drop its strobe. -> IDLE.
- Latency: request visible at edge t -> strobe at t+1 -> resp to cache in the same cycle as pmem_resp.
- Minimum gap between back-to-back transactions is 2 cycles (DONE + IDLE).
- Streak counter, 4-bit:
  - On a D grant while i_pmem_read=1, streak+1 (saturates at max_d_streak).
  - On any I grant, streak=0.
  - On a D grant with no I request, streak=0.
- Requester inputs may change or drop while BUSY. The latched values are used; a dropped request still completes, and its resp is issued and ignored.
- d_pmem_read and d_pmem_write both high at grant: write is taken (illegal input; simulation assertion fires).
- pmem_resp in IDLE or DONE is ignored; no resp is forwarded.
- Reset mid-transaction: immediate return to IDLE, strobes drop, no resp issued, streak cleared.
- Never both resps in one cycle; never both pmem strobes in one cycle.

Test Plan:
- I-only fill:
  - Stimulus: i_pmem_read=1, address 0x0000_0060; memory responds after 3 cycles with rdata = 256'hA5...
  - Required: pmem_read high 3 cycles with pmem_address=0x60, i_pmem_resp pulses once with i_pmem_rdata=A5..., d_pmem_resp stays 0, DONE lasts 1 cycle.
- D write-back:
  - Stimulus: d_pmem_write=1, address 0x0000_1F20, wdata = 256'h1234...
  - Required: pmem_write=1 with pmem_wdata=1234... and pmem_read=0; d_pmem_resp pulses on pmem_resp.
- Simultaneous request:
  - Stimulus: I and D both request in IDLE, streak=0.
  - Required: D granted first; I granted 2 cycles after d_pmem_resp; streak returns to 0.
- Starvation guard:
  - Stimulus: D requests continuously with I held high.
  - Required: exactly 4 D transactions, then the I transaction, then D resumes.
- Request drop and stray resp:
  - Stimulus: D requests address 0x40, then changes its address to 0x80 while D_BUSY.
  - Required: pmem_address stays 0x40.
  - Stimulus: pmem_resp while IDLE.
  - Required: no resp output.
- Reset mid-op:
  - Stimulus: assert rst during I_BUSY between clock edges.
  - Required: pmem_read falls before the next edge, i_pmem_resp stays 0, post-reset state is IDLE, and a fresh request is granted normally.
